// File: rtl/pipe_reg_slice.sv
// Multi-stage valid/ready register slice with bubble collapsing; optional occupancy port under PIPE_REG_SLICE_OCC_EN.
// Latency DEPTH cycles with no stalls; out_valid/out_data come straight from the last stage register.
// Backpressure: out_ready ripples combinationally back to in_ready through empty or advancing stages.
module pipe_reg_slice #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_SLICE_OCC_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

   logic [DEPTH-1:0] valid_q;
   logic [WIDTH-1:0] data_q [DEPTH];

   // room[i]: stage i can take a word this cycle; room[DEPTH] is the downstream ready
   logic [DEPTH:0]   room;
   logic [DEPTH-1:0] load;
   logic [DEPTH-1:0] leave;

   always_comb begin
      logic r;
      r = out_ready;
      room = '0;
      room[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         r = ~valid_q[i] | r;
         room[i] = r;
      end
   end

   assign in_ready = room[0] & ~flush & ~reset;

   always_comb begin
      load  = '0;
      leave = '0;
      load[0] = in_valid & in_ready;
      for (int i = 1; i < DEPTH; i++) begin
         load[i] = valid_q[i-1] & room[i];
      end
      for (int i = 0; i < DEPTH; i++) begin
         leave[i] = valid_q[i] & room[i+1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= ~flush & (load[i] | (valid_q[i] & ~leave[i]));
         end
         if (load[0]) begin
            data_q[0] <= in_data;
         end
         // Internal shifts are suppressed on flush so cleared stages keep their old data
         for (int i = 1; i < DEPTH; i++) begin
            if (load[i] && !flush) begin
               data_q[i] <= data_q[i-1];
            end
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];

`ifdef PIPE_REG_SLICE_OCC_EN
   localparam int OCC_W = $clog2(DEPTH + 1);

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy = occupancy + OCC_W'(valid_q[i]);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_reg_slice.sv
// Directed bench for pipe_reg_slice at DEPTH 2, 3 and 4 with per-instance scoreboards.
module tb_pipe_reg_slice;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   logic       a_flush, a_iv, a_ir, a_ov, a_ordy;
   logic [3:0] a_id, a_od;
   logic       b_flush, b_iv, b_ir, b_ov, b_ordy;
   logic [3:0] b_id, b_od;
   logic       c_flush, c_iv, c_ir, c_ov, c_ordy;
   logic [3:0] c_id, c_od;
`ifdef PIPE_REG_SLICE_OCC_EN
   logic [1:0] a_occ, b_occ;
   logic [2:0] c_occ;
`endif

   pipe_reg_slice #(.WIDTH(4), .DEPTH(2)) u_a (
      .clk(clk), .reset(reset), .flush(a_flush),
      .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
      .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od)
`ifdef PIPE_REG_SLICE_OCC_EN
      , .occupancy(a_occ)
`endif
   );

   pipe_reg_slice #(.WIDTH(4), .DEPTH(3)) u_b (
      .clk(clk), .reset(reset), .flush(b_flush),
      .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
      .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od)
`ifdef PIPE_REG_SLICE_OCC_EN
      , .occupancy(b_occ)
`endif
   );

   pipe_reg_slice #(.WIDTH(4), .DEPTH(4)) u_c (
      .clk(clk), .reset(reset), .flush(c_flush),
      .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
      .out_valid(c_ov), .out_ready(c_ordy), .out_data(c_od)
`ifdef PIPE_REG_SLICE_OCC_EN
      , .occupancy(c_occ)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Scoreboards: push on accepted input, pop and compare on output transfer
   logic [3:0] qa[$];
   logic [3:0] qb[$];
   logic [3:0] qc[$];

   always @(negedge clk) begin
      if (reset) begin
         qa.delete();
      end else begin
         if (a_ov && a_ordy) begin
            chk("a_unexpected_out", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) chk("a_out_data", 64'(a_od), 64'(qa.pop_front()));
         end
         if (a_iv && a_ir) qa.push_back(a_id);
         if (a_flush) qa.delete();
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         qb.delete();
      end else begin
         if (b_ov && b_ordy) begin
            chk("b_unexpected_out", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) chk("b_out_data", 64'(b_od), 64'(qb.pop_front()));
         end
         if (b_iv && b_ir) qb.push_back(b_id);
         if (b_flush) qb.delete();
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         qc.delete();
      end else begin
         if (c_ov && c_ordy) begin
            chk("c_unexpected_out", 64'(qc.size() != 0), 64'd1);
            if (qc.size() != 0) chk("c_out_data", 64'(c_od), 64'(qc.pop_front()));
         end
         if (c_iv && c_ir) qc.push_back(c_id);
         if (c_flush) qc.delete();
      end
   end

   initial begin
      reset = 1'b1;
      a_flush = 0; a_iv = 0; a_ordy = 0; a_id = 0;
      b_flush = 0; b_iv = 0; b_ordy = 0; b_id = 0;
      c_flush = 0; c_iv = 0; c_ordy = 0; c_id = 0;

      // Reset state
      tick(); tick();
      mid();
      chk("rst_a_ov", 64'(a_ov), 64'd0);
      chk("rst_a_od", 64'(a_od), 64'd0);
      chk("rst_a_ir", 64'(a_ir), 64'd0);
      chk("rst_c_ov", 64'(c_ov), 64'd0);
      tick();
      reset = 1'b0;
      mid();
      chk("post_rst_a_ir", 64'(a_ir), 64'd1);
      chk("post_rst_b_ir", 64'(b_ir), 64'd1);
      chk("post_rst_c_ir", 64'(c_ir), 64'd1);

      // Single word through DEPTH=2
      tick();
      a_iv = 1; a_id = 4'hA; a_ordy = 1;
      mid();
      chk("t1_ir", 64'(a_ir), 64'd1);
      tick();
      a_iv = 0;
      mid();
      chk("t1_ov_early", 64'(a_ov), 64'd0);
      tick();
      mid();
      chk("t1_ov", 64'(a_ov), 64'd1);
      chk("t1_od", 64'(a_od), 64'hA);
`ifdef PIPE_REG_SLICE_OCC_EN
      chk("t1_occ", 64'(a_occ), 64'd1);
`endif
      tick();
      mid();
      chk("t1_ov_after", 64'(a_ov), 64'd0);
      chk("t1_od_retained", 64'(a_od), 64'hA);

      // DEPTH=3 fill under stall, then release
      tick();
      b_ordy = 0; b_iv = 1; b_id = 4'h1;
      mid();
      chk("t2_ir_w1", 64'(b_ir), 64'd1);
      tick();
      b_id = 4'h2;
      mid();
      chk("t2_ir_w2", 64'(b_ir), 64'd1);
      tick();
      b_id = 4'h3;
      mid();
      chk("t2_ir_w3", 64'(b_ir), 64'd1);
      tick();
      b_id = 4'h4;
      mid();
      chk("t2_ir_full", 64'(b_ir), 64'd0);
`ifdef PIPE_REG_SLICE_OCC_EN
      chk("t2_occ", 64'(b_occ), 64'd3);
`endif
      tick();
      mid();
      chk("t2_hold_ir", 64'(b_ir), 64'd0);
      chk("t2_hold_ov", 64'(b_ov), 64'd1);
      chk("t2_hold_od", 64'(b_od), 64'h1);
      tick();
      b_ordy = 1;
      mid();
      chk("t2_ready_prop", 64'(b_ir), 64'd1);
      tick();
      b_iv = 0;
      repeat (5) tick();
      mid();
      chk("t2_drained_ov", 64'(b_ov), 64'd0);

      // DEPTH=2 full with simultaneous in/out
      tick();
      a_ordy = 0; a_iv = 1; a_id = 4'h1;
      tick();
      a_id = 4'h2;
      tick();
      a_id = 4'h3;
      mid();
      chk("t3_full_ir", 64'(a_ir), 64'd0);
      tick();
      mid();
      chk("t3_full_od", 64'(a_od), 64'h1);
      tick();
      a_ordy = 1;
      mid();
      chk("t3_ir_a", 64'(a_ir), 64'd1);
`ifdef PIPE_REG_SLICE_OCC_EN
      chk("t3_occ_a", 64'(a_occ), 64'd2);
`endif
      tick();
      a_id = 4'h4;
      mid();
      chk("t3_ir_b", 64'(a_ir), 64'd1);
      chk("t3_od_b", 64'(a_od), 64'h2);
`ifdef PIPE_REG_SLICE_OCC_EN
      chk("t3_occ_b", 64'(a_occ), 64'd2);
`endif
      tick();
      a_id = 4'h5;
      mid();
      chk("t3_ir_c", 64'(a_ir), 64'd1);
      chk("t3_od_c", 64'(a_od), 64'h3);
      tick();
      a_iv = 0;
      repeat (3) tick();
      mid();
      chk("t3_drained_ov", 64'(a_ov), 64'd0);

      // DEPTH=4 bubble collapse
      tick();
      c_ordy = 0; c_iv = 1; c_id = 4'h5;
      tick();
      c_iv = 0;
      tick(); tick();
      c_iv = 1; c_id = 4'h6;
      tick();
      c_iv = 0;
      repeat (4) tick();
      mid();
      chk("t4_ov", 64'(c_ov), 64'd1);
      chk("t4_od", 64'(c_od), 64'h5);
      chk("t4_ir", 64'(c_ir), 64'd1);
`ifdef PIPE_REG_SLICE_OCC_EN
      chk("t4_occ", 64'(c_occ), 64'd2);
`endif
      tick();
      c_ordy = 1;
      mid();
      chk("t4_pop_od", 64'(c_od), 64'h5);
      tick();
      c_ordy = 0;
      mid();
      chk("t4_next_ov", 64'(c_ov), 64'd1);
      chk("t4_next_od", 64'(c_od), 64'h6);
      tick();
      c_ordy = 1;
      repeat (2) tick();
      mid();
      chk("t4_drained_ov", 64'(c_ov), 64'd0);

      // Flush on DEPTH=3 with an input offered
      tick();
      b_ordy = 0; b_iv = 1; b_id = 4'h7;
      tick();
      b_id = 4'h8;
      tick();
      b_iv = 0;
      tick(); tick();
      mid();
      chk("t5_pre_ov", 64'(b_ov), 64'd1);
`ifdef PIPE_REG_SLICE_OCC_EN
      chk("t5_pre_occ", 64'(b_occ), 64'd2);
`endif
      tick();
      b_iv = 1; b_id = 4'h9; b_flush = 1;
      mid();
      chk("t5_flush_ir", 64'(b_ir), 64'd0);
      tick();
      b_flush = 0; b_iv = 0;
      mid();
      chk("t5_post_ov", 64'(b_ov), 64'd0);
      chk("t5_post_ir", 64'(b_ir), 64'd1);
`ifdef PIPE_REG_SLICE_OCC_EN
      chk("t5_post_occ", 64'(b_occ), 64'd0);
`endif
      tick();
      b_ordy = 1;
      repeat (4) tick();
      mid();
      chk("t5_no_capture_ov", 64'(b_ov), 64'd0);

      chk("sb_a_empty", 64'(qa.size()), 64'd0);
      chk("sb_b_empty", 64'(qb.size()), 64'd0);
      chk("sb_c_empty", 64'(qc.size()), 64'd0);

      // Reset beats flush and handshake on a full DEPTH=2 pipe
      tick();
      a_ordy = 0; a_iv = 1; a_id = 4'hC;
      tick();
      a_id = 4'hD;
      tick();
      a_id = 4'hE; a_flush = 1; reset = 1;
      mid();
      chk("t6_rst_ir", 64'(a_ir), 64'd0);
      tick();
      mid();
      chk("t6_ov", 64'(a_ov), 64'd0);
      chk("t6_od", 64'(a_od), 64'd0);
      chk("t6_ir_held", 64'(a_ir), 64'd0);
`ifdef PIPE_REG_SLICE_OCC_EN
      chk("t6_occ", 64'(a_occ), 64'd0);
`endif
      tick();
      reset = 0; a_flush = 0; a_iv = 0;
      mid();
      chk("t6_release_ir", 64'(a_ir), 64'd1);
      chk("t6_release_ov", 64'(a_ov), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
